// File: rtl/io_ring_pwr_seq.sv
// IO-ring power sequencer: enables supply segments one by one after per-step
// delays, waits for each power-good, shuts down in reverse order, traps faults.
module io_ring_pwr_seq #(
    parameter int N_CH  = 4,
    parameter int DLY_W = 8,
    parameter int TMO_W = 12,
    localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_on,
    input  logic [N_CH-1:0]  pg_i,
    input  logic [DLY_W-1:0] dly_cfg,
    input  logic [TMO_W-1:0] tmo_cfg,
    input  logic             fault_clr,
    output logic [N_CH-1:0]  en_o,
    output logic             all_on,
    output logic             busy,
    output logic             fault,
    output logic [IW-1:0]    fault_ch
);

    localparam int CW = (DLY_W > TMO_W) ? DLY_W : TMO_W;

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_UP      = 3'd1;
    localparam logic [2:0] S_WAIT_PG = 3'd2;
    localparam logic [2:0] S_ON      = 3'd3;
    localparam logic [2:0] S_DOWN    = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [IW-1:0]   IDX_LAST = IW'(N_CH - 1);
    localparam logic [N_CH-1:0] ALL_ONES = {N_CH{1'b1}};

    logic [N_CH-1:0] pg_s1_q, pg_s_q;
    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0] en_q, en_d;
    logic [IW-1:0]   fault_ch_q, fault_ch_d;
    logic            all_on_q, busy_q, fault_q;
    logic [IW-1:0]   drop_idx;
    logic [CW-1:0]   dly_ld, tmo_ld;

    assign dly_ld = CW'(dly_cfg);
    assign tmo_ld = CW'(tmo_cfg);

    // Lowest segment whose power-good has gone away.
    always_comb begin
        drop_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!pg_s_q[i]) drop_idx = IW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        en_d       = en_q;
        fault_ch_d = fault_ch_q;
        case (state_q)
            S_OFF: begin
                en_d = '0;
                if (req_on) begin
                    state_d = S_UP;
                    idx_d   = '0;
                    cnt_d   = dly_ld;
                end
            end
            S_UP: begin
                if (!req_on) begin
                    state_d = S_DOWN;
                    cnt_d   = dly_ld;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    en_d[idx_q] = 1'b1;
                    state_d     = S_WAIT_PG;
                    cnt_d       = tmo_ld;
                end
            end
            S_WAIT_PG: begin
                if (!req_on) begin
                    state_d = S_DOWN;
                    cnt_d   = dly_ld;
                end else if (pg_s_q[idx_q]) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_ON;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = dly_ld;
                        state_d = S_UP;
                    end
                end else if (cnt_q == '0) begin
                    state_d    = S_FAULT;
                    fault_ch_d = idx_q;
                    en_d       = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ON: begin
                // A brown-out outranks a simultaneous power-down request.
                if (pg_s_q != ALL_ONES) begin
                    state_d    = S_FAULT;
                    fault_ch_d = drop_idx;
                    en_d       = '0;
                end else if (!req_on) begin
                    state_d = S_DOWN;
                    idx_d   = IDX_LAST;
                    cnt_d   = dly_ld;
                end
            end
            S_DOWN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    en_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d = idx_q - 1'b1;
                        cnt_d = dly_ld;
                    end
                end
            end
            S_FAULT: begin
                en_d = '0;
                if (fault_clr && !req_on) state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pg_s1_q    <= '0;
            pg_s_q     <= '0;
            state_q    <= S_OFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            en_q       <= '0;
            fault_ch_q <= '0;
            all_on_q   <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pg_s1_q    <= pg_i;
            pg_s_q     <= pg_s1_q;
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            fault_ch_q <= fault_ch_d;
            all_on_q   <= (state_d == S_ON);
            busy_q     <= (state_d == S_UP) || (state_d == S_WAIT_PG) || (state_d == S_DOWN);
            fault_q    <= (state_d == S_FAULT);
        end
    end

    assign en_o     = en_q;
    assign all_on   = all_on_q;
    assign busy     = busy_q;
    assign fault    = fault_q;
    assign fault_ch = fault_ch_q;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Directed bench for io_ring_pwr_seq: power-good is modelled as en_o delayed
// by 5 cycles, with a per-bit mask to simulate missing or collapsing supplies.
module tb_io_ring_pwr_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_on;
    logic [3:0]  pg_i;
    logic [7:0]  dly_cfg;
    logic [11:0] tmo_cfg;
    logic        fault_clr;
    logic [3:0]  en_o;
    logic        all_on, busy, fault;
    logic [1:0]  fault_ch;

    logic [3:0]  hist [5];
    logic [3:0]  pg_mask;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n;

    io_ring_pwr_seq #(.N_CH(4), .DLY_W(8), .TMO_W(12)) dut (
        .CLK(CLK), .RST(RST), .req_on(req_on), .pg_i(pg_i),
        .dly_cfg(dly_cfg), .tmo_cfg(tmo_cfg), .fault_clr(fault_clr),
        .en_o(en_o), .all_on(all_on), .busy(busy), .fault(fault), .fault_ch(fault_ch)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 5; i++) hist[i] <= '0;
        end else begin
            hist[0] <= en_o;
            for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
        end
    end

    assign pg_i = hist[4] & pg_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_en(input logic [3:0] exp, input int lim, output int cnt);
        cnt = 0;
        while (en_o !== exp && cnt < lim) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        RST = 1'b1; req_on = 1'b0; pg_mask = 4'hF;
        dly_cfg = 8'd3; tmo_cfg = 12'd100; fault_clr = 1'b0;
        repeat (3) tick();
        chk("rst_en", en_o, 4'h0);
        chk("rst_all_on", all_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_ch", fault_ch, 0);
        RST = 1'b0;
        repeat (2) tick();
        chk("idle_busy", busy, 0);

        // power-up, dly_cfg=3
        req_on = 1'b1;
        wait_en(4'b0001, 50, n);  chk("up_step0_edges", n, 5);
        chk("up_busy", busy, 1);
        wait_en(4'b0011, 50, n);  chk("up_step1_edges", n, 12);
        wait_en(4'b0111, 50, n);  chk("up_step2_edges", n, 12);
        wait_en(4'b1111, 50, n);  chk("up_step3_edges", n, 12);
        n = 0;
        while (!all_on && n < 50) begin tick(); n++; end
        chk("all_on_edges", n, 8);
        chk("on_busy", busy, 0);
        chk("on_fault", fault, 0);

        // power-down, dly_cfg=2
        dly_cfg = 8'd2;
        req_on  = 1'b0;
        wait_en(4'b0111, 50, n);  chk("dn_step3_edges", n, 4);
        wait_en(4'b0011, 50, n);  chk("dn_step2_edges", n, 3);
        wait_en(4'b0001, 50, n);  chk("dn_step1_edges", n, 3);
        wait_en(4'b0000, 50, n);  chk("dn_step0_edges", n, 3);
        chk("dn_off_busy", busy, 0);
        chk("dn_off_all_on", all_on, 0);
        repeat (8) tick();

        // power-good timeout on segment 2
        dly_cfg = 8'd1; tmo_cfg = 12'd10; pg_mask = 4'b1011;
        req_on  = 1'b1;
        wait_en(4'b0111, 100, n); chk("tmo_reach_0111", en_o, 4'b0111);
        n = 0;
        while (!fault && n < 50) begin tick(); n++; end
        chk("tmo_edges", n, 11);
        chk("tmo_en", en_o, 4'h0);
        chk("tmo_fault_ch", fault_ch, 2);
        chk("tmo_busy", busy, 0);
        fault_clr = 1'b1;
        tick();
        chk("tmo_clr_req_on_hold", fault, 1);
        req_on = 1'b0;
        tick();
        fault_clr = 1'b0;
        chk("tmo_clr_fault", fault, 0);
        chk("tmo_clr_en", en_o, 4'h0);
        chk("tmo_fault_ch_hold", fault_ch, 2);
        pg_mask = 4'hF;
        repeat (8) tick();

        // brown-out of segments 1 and 3 while ON
        tmo_cfg = 12'd50;
        req_on  = 1'b1;
        n = 0;
        while (!all_on && n < 200) begin tick(); n++; end
        chk("bo_reach_on", all_on, 1);
        pg_mask = 4'b0101;
        n = 0;
        while (!fault && n < 20) begin tick(); n++; end
        chk("bo_edges", n, 3);
        chk("bo_fault_ch", fault_ch, 1);
        chk("bo_en", en_o, 4'h0);
        chk("bo_all_on", all_on, 0);
        req_on = 1'b0; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0; pg_mask = 4'hF;
        chk("bo_clr", fault, 0);
        repeat (8) tick();

        // abort during WAIT_PG at idx 1, with an ignored req_on pulse in DOWN
        req_on = 1'b1;
        wait_en(4'b0011, 100, n); chk("ab_reach_0011", en_o, 4'b0011);
        req_on = 1'b0;
        tick();
        chk("ab_down_busy", busy, 1);
        chk("ab_down_en", en_o, 4'b0011);
        req_on = 1'b1;
        tick();
        req_on = 1'b0;
        tick();
        chk("ab_clear1", en_o, 4'b0001);
        repeat (2) tick();
        chk("ab_clear0", en_o, 4'b0000);
        chk("ab_off_busy", busy, 0);
        repeat (3) tick();
        chk("ab_stay_off", en_o, 4'b0000);
        repeat (5) tick();

        // asynchronous reset in UP with en_o=0011
        dly_cfg = 8'd3; tmo_cfg = 12'd100;
        req_on  = 1'b1;
        wait_en(4'b0011, 100, n); chk("ar_reach_0011", en_o, 4'b0011);
        repeat (9) tick();
        chk("ar_mid_up_en", en_o, 4'b0011);
        chk("ar_mid_up_busy", busy, 1);
        #2 RST = 1'b1;
        #1;
        chk("ar_en_async", en_o, 4'h0);
        chk("ar_busy_async", busy, 0);
        req_on = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        repeat (4) tick();
        chk("ar_stay_off_en", en_o, 4'h0);
        chk("ar_stay_off_busy", busy, 0);
        req_on = 1'b1;
        tick();
        chk("ar_restart_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_ring_pwr_seq.md
IO_RING_PWR_SEQ -- requirements
Module: io_ring_pwr_seq

Interface
REQ-001 Parameter N_CH, default 4, meaning: number of IO-ring supply segments sequenced (1..16).
REQ-002 Parameter DLY_W, default 8, meaning: width of the inter-step delay counter.
REQ-003 Parameter TMO_W, default 12, meaning: width of the power-good timeout counter.
REQ-004 CLK  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 req_on  input  1  level request: 1 = ring powered, 0 = ring off.
REQ-007 pg_i  input  N_CH  per-segment power-good, asynchronous to CLK.
REQ-008 dly_cfg  input  DLY_W  inter-step delay, sampled at every delay reload.
REQ-009 tmo_cfg  input  TMO_W  power-good timeout, sampled at every timeout reload.
REQ-010 fault_clr  input  1  single-cycle fault acknowledge.
REQ-011 en_o  output  N_CH  registered per-segment supply enable.
REQ-012 all_on  output  1  high only in state ON.
REQ-013 busy  output  1  high in UP, WAIT_PG and DOWN.
REQ-014 fault  output  1  high only in state FAULT.
REQ-015 fault_ch  output  $clog2(N_CH) (min 1)  index of the segment that caused the last fault; holds until the next fault.

Function
REQ-016 pg_i SHALL pass through a 2-flop synchroniser per bit (pg_s); all decisions use pg_s only.
REQ-017 FSM states SHALL be OFF, UP, WAIT_PG, ON, DOWN and FAULT; idx SHALL be a step index of width $clog2(N_CH); cnt SHALL be a shared down-counter of width max(DLY_W,TMO_W).
REQ-018 OFF: en_o=0. If req_on=1, go to UP with idx=0 and cnt=dly_cfg.
REQ-019 UP: if cnt!=0, decrement cnt; if cnt==0, set en_o[idx]=1, go to WAIT_PG and set cnt=tmo_cfg. Each enable SHALL therefore rise dly_cfg+1 edges after the FSM enters UP.
REQ-020 WAIT_PG: if pg_s[idx]=1 and idx=N_CH-1, go to ON. If pg_s[idx]=1 and idx<N_CH-1, increment idx, set cnt=dly_cfg and go to UP. If pg_s[idx]=0 and cnt==0, go to FAULT with fault_ch=idx. Otherwise decrement cnt.
REQ-021 ON: if req_on=0, go to DOWN with idx=N_CH-1 and cnt=dly_cfg. If any pg_s bit drops, go to FAULT with fault_ch set to the lowest dropped index. If both conditions occur in the same cycle, the fault SHALL take priority.
REQ-022 DOWN: if cnt!=0, decrement cnt; if cnt==0, clear en_o[idx]. Then, if idx==0, go to OFF; otherwise decrement idx and set cnt=dly_cfg. Segments SHALL shut down in reverse order.
REQ-023 If req_on=0 while in UP or WAIT_PG, the next state SHALL be DOWN with the current idx and cnt=dly_cfg. Clearing a segment that is already low is a normal delay step with no other effect.
REQ-024 While in DOWN, req_on=1 SHALL be ignored; power-up resumes only after the FSM reaches OFF.
REQ-025 Entering FAULT SHALL clear all en_o bits on the same edge. FAULT SHALL go to OFF only when fault_clr=1 and req_on=0 in the same cycle; fault_clr outside FAULT SHALL have no effect.
REQ-026 dly_cfg=0 and tmo_cfg=0 SHALL each give a 1-cycle step. Counters SHALL never wrap below zero.
REQ-027 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-028 While RST=1, the FSM SHALL be in OFF, with en_o=0, all_on=0, busy=0, fault=0, fault_ch=0, idx=0, cnt=0 and the synchroniser flops at 0.
REQ-029 Asserting RST in any state, including mid-sequence, SHALL clear en_o immediately without waiting for a clock edge. After release, the block SHALL wait in OFF until it samples req_on=1.

Verification
REQ-030 Power-up: N_CH=4, dly_cfg=3, pg_i follows en_o after 5 cycles, req_on=1 -> en_o steps 0001, 0011, 0111, 1111 in order; each bit rises 4 edges after UP is entered; all_on=1 after pg_s[3]; busy=0 in ON.
REQ-031 Power-down: from ON, set req_on=0 with dly_cfg=2 -> en_o steps 0111, 0011, 0001, 0000, one bit every 3 edges; then OFF with busy=0.
REQ-032 Timeout: tmo_cfg=10 and pg_i[2] held 0 -> FAULT 11 edges after en_o[2] rises; en_o=0; fault=1; fault_ch=2. fault_clr with req_on=1 -> stays in FAULT; fault_clr with req_on=0 -> OFF.
REQ-033 Brown-out: in ON, drop pg_i[1] and pg_i[3] together -> fault=1 and fault_ch=1 three edges later (synchroniser plus FSM).
REQ-034 Abort: drop req_on during WAIT_PG at idx=1 -> DOWN clears en_o[1] and then en_o[0]; a req_on pulse during DOWN is ignored.
REQ-035 Async reset: assert RST mid-UP with en_o=0011 -> en_o=0000 before the next CLK edge; the block stays in OFF after RST is released.
